// File: rtl/regfile_writeback.sv
// regfile_writeback: 8-entry register file write side with ALU/load arbitration, load skid buffer and busy scoreboard.
module regfile_writeback #(
  parameter int DATA_W = 16,
  parameter bit ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_we,
  input  logic [2:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_issue,
  input  logic [2:0]        ld_issue_rd,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [2:0]        ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [2:0]        src_a_idx,
  input  logic [2:0]        src_b_idx,
  input  logic [2:0]        src_c_idx,
  input  logic [2:0]        dst_idx,
  output logic              hazard,
  output logic [DATA_W-1:0] reg0out,
  output logic [DATA_W-1:0] reg1out,
  output logic [DATA_W-1:0] reg2out,
  output logic [DATA_W-1:0] reg3out,
  output logic [DATA_W-1:0] reg4out,
  output logic [DATA_W-1:0] reg5out,
  output logic [DATA_W-1:0] reg6out,
  output logic [DATA_W-1:0] reg7out
);
  logic [DATA_W-1:0] regs [8];
  logic [7:0]        busy;
  logic              buf_valid;
  logic [2:0]        buf_rd;
  logic [DATA_W-1:0] buf_data;
  logic              accept;
  logic              wld;
  logic              wv;
  logic [2:0]        wrd;
  logic [DATA_W-1:0] wdata;
  logic [7:0]        bmask;
  assign ld_ready = !buf_valid;
  assign accept   = ld_valid && !buf_valid;
  assign bmask    = {7'h7f, ~ZERO_R0};
  // ALU wins the single write port; a buffered load drains before a fresh one can write
  always_comb begin
    wld   = !alu_we && (buf_valid || accept);
    wv    = alu_we || wld;
    wrd   = alu_we ? alu_rd : buf_valid ? buf_rd : ld_rd;
    wdata = alu_we ? alu_data : buf_valid ? buf_data : ld_data;
  end
  assign hazard = |(busy & bmask & ((8'd1 << src_a_idx) | (8'd1 << src_b_idx) |
                                    (8'd1 << src_c_idx) | (8'd1 << dst_idx)));
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      busy      <= '0;
      buf_valid <= 1'b0;
      buf_rd    <= '0;
      buf_data  <= '0;
    end else begin
      if (wv && (wrd != 3'd0 || !ZERO_R0)) regs[wrd] <= wdata;
      buf_valid <= alu_we && (buf_valid || accept);
      if (alu_we && accept) begin
        buf_rd   <= ld_rd;
        buf_data <= ld_data;
      end
      busy <= (busy & ~(wld ? 8'd1 << wrd : 8'd0)) | ((ld_issue ? 8'd1 << ld_issue_rd : 8'd0) & bmask);
    end
  end
  assign reg0out = ZERO_R0 ? '0 : regs[0];
  assign reg1out = regs[1];
  assign reg2out = regs[2];
  assign reg3out = regs[3];
  assign reg4out = regs[4];
  assign reg5out = regs[5];
  assign reg6out = regs[6];
  assign reg7out = regs[7];
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed plan plus random traffic against a queue-based reference model.
module tb_regfile_writeback;
  logic clk = 0, rst = 0;
  logic alu_we = 0, ld_issue = 0, ld_valid = 0, ld_ready, hazard;
  logic [2:0] alu_rd = 0, ld_issue_rd = 0, ld_rd = 0;
  logic [2:0] src_a_idx = 0, src_b_idx = 0, src_c_idx = 0, dst_idx = 0;
  logic [15:0] alu_data = 0, ld_data = 0;
  logic [15:0] rout [8];
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [2:0] rd; logic [15:0] d;} ld_t;
  ld_t q[$];
  logic [15:0] m_reg [8];
  bit m_busy [8];

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk(clk), .rst(rst), .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_rd(ld_rd), .ld_data(ld_data), .src_a_idx(src_a_idx), .src_b_idx(src_b_idx),
    .src_c_idx(src_c_idx), .dst_idx(dst_idx), .hazard(hazard),
    .reg0out(rout[0]), .reg1out(rout[1]), .reg2out(rout[2]), .reg3out(rout[3]),
    .reg4out(rout[4]), .reg5out(rout[5]), .reg6out(rout[6]), .reg7out(rout[7])
  );

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit busy_at(logic [2:0] i);
    return i != 0 && m_busy[i];
  endfunction

  task automatic wr(logic [2:0] rd, logic [15:0] d);
    if (rd != 0) m_reg[rd] = d;
  endtask

  // Loads join a FIFO; whenever the ALU is idle the oldest pending load retires
  task automatic step();
    ld_t e;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_reg[i] = 0; m_busy[i] = 0; end
      q.delete();
    end else begin
      if (ld_valid && q.size() == 0) q.push_back('{ld_rd, ld_data});
      if (alu_we) wr(alu_rd, alu_data);
      else if (q.size() > 0) begin
        e = q.pop_front();
        wr(e.rd, e.d);
        m_busy[e.rd] = 0;
      end
      if (ld_issue && ld_issue_rd != 0) m_busy[ld_issue_rd] = 1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), rout[i], m_reg[i]);
    chk("ld_ready", {15'd0, ld_ready}, {15'd0, q.size() == 0});
    chk("hazard", {15'd0, hazard},
        {15'd0, busy_at(src_a_idx) | busy_at(src_b_idx) | busy_at(src_c_idx) | busy_at(dst_idx)});
  endtask

  initial begin
    #1;
    rst = 1; step(); rst = 0;
    chk("rst_reg3", rout[3], 16'h0);
    chk("rst_ready", {15'd0, ld_ready}, 16'd1);
    chk("rst_hazard", {15'd0, hazard}, 16'd0);
    alu_we = 1; alu_rd = 3; alu_data = 16'hBEEF; step();
    chk("alu_r3", rout[3], 16'hBEEF);
    alu_rd = 0; alu_data = 16'h1234; step(); alu_we = 0;
    chk("alu_r0", rout[0], 16'h0);
    ld_issue = 1; ld_issue_rd = 0; src_a_idx = 0; step();
    chk("r0_busy", {15'd0, hazard}, 16'd0);
    ld_issue_rd = 5; src_b_idx = 5; step(); ld_issue = 0;
    chk("busy5", {15'd0, hazard}, 16'd1);
    step();
    ld_valid = 1; ld_rd = 5; ld_data = 16'h00A5; step(); ld_valid = 0;
    chk("ld_r5", rout[5], 16'h00A5);
    chk("ld_r5_haz", {15'd0, hazard}, 16'd0);
    ld_issue = 1; ld_issue_rd = 2; step(); ld_issue = 0;
    ld_valid = 1; ld_rd = 2; ld_data = 16'h2222; alu_we = 1; alu_rd = 4; alu_data = 16'h4444; src_a_idx = 2;
    step(); ld_valid = 0;
    chk("col_r4", rout[4], 16'h4444);
    chk("col_ready", {15'd0, ld_ready}, 16'd0);
    alu_rd = 6;
    for (int i = 0; i < 3; i++) begin
      alu_data = 16'h6000 + 16'(i); step();
      chk("hold_ready", {15'd0, ld_ready}, 16'd0);
      chk("hold_busy2", {15'd0, hazard}, 16'd1);
      chk("hold_r2", rout[2], 16'h0);
    end
    alu_we = 0; step();
    chk("drain_r2", rout[2], 16'h2222);
    chk("drain_ready", {15'd0, ld_ready}, 16'd1);
    chk("drain_haz", {15'd0, hazard}, 16'd0);
    ld_issue = 1; ld_issue_rd = 1; step(); ld_issue = 0;
    ld_valid = 1; ld_rd = 1; ld_data = 16'h1111; alu_we = 1; alu_rd = 6; alu_data = 16'h6666; step();
    ld_valid = 0; alu_we = 0; ld_issue = 1; ld_issue_rd = 1; src_a_idx = 1; step(); ld_issue = 0;
    chk("setwin_r1", rout[1], 16'h1111);
    chk("setwin_haz", {15'd0, hazard}, 16'd1);
    step();
    chk("setwin_haz2", {15'd0, hazard}, 16'd1);
    ld_valid = 1; ld_rd = 1; ld_data = 16'h0101; step(); ld_valid = 0;
    chk("clr1_haz", {15'd0, hazard}, 16'd0);
    ld_issue = 1; ld_issue_rd = 2; src_a_idx = 2; step(); ld_issue = 0;
    ld_valid = 1; ld_rd = 2; ld_data = 16'hDEAD; alu_we = 1; alu_rd = 7; alu_data = 16'h7777; step();
    ld_valid = 0; alu_we = 0; rst = 1; step(); rst = 0;
    chk("rstbuf_r7", rout[7], 16'h0);
    chk("rstbuf_ready", {15'd0, ld_ready}, 16'd1);
    chk("rstbuf_haz", {15'd0, hazard}, 16'd0);
    step();
    chk("rstbuf_r2", rout[2], 16'h0);
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(63) == 0);
      alu_we = $urandom_range(1); alu_rd = 3'($urandom); alu_data = 16'($urandom);
      ld_valid = $urandom_range(1); ld_rd = 3'($urandom); ld_data = 16'($urandom);
      ld_issue = ($urandom_range(2) == 0); ld_issue_rd = 3'($urandom);
      src_a_idx = 3'($urandom); src_b_idx = 3'($urandom);
      src_c_idx = 3'($urandom); dst_idx = 3'($urandom);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
